mac_issue_ctrl: RTL and testbench
=================================

MAC_ISSUE_CTRL -- requirements
Module: mac_issue_ctrl

Interface
REQ-001 SHALL have parameter MAC_LAT, default 3, meaning cycles from mac_en high to mac_result valid.
REQ-002 SHALL have parameter RSP_DEPTH, default 4, a power of two ≥ 2, meaning response FIFO entries.
REQ-003 SHALL have CLK, input, 1, clock; RST, input, 1, reset, synchronous, active-high.
REQ-004 SHALL have req_valid in 1, req_ready out 1, req_m1 in 32, req_m2 in 32, req_addend in 32, req_tag in 4: operand request handshake.
REQ-005 SHALL have mac_multiplicand1 out 32, mac_multiplicand2 out 32, mac_addend out 32, mac_en out 1, mac_rdy_get in 1: MAC operand port.
REQ-006 SHALL have mac_result in 64 and mac_rdy_result in 1: MAC result port.
REQ-007 SHALL have rsp_valid out 1, rsp_ready in 1, rsp_data out 64, rsp_tag out 4: result handshake.
REQ-008 SHALL have flush in 1, busy out 1 and err out 1 (sticky protocol error).

Function
REQ-009 SHALL transfer a request when req_valid && req_ready; in the same cycle it SHALL drive mac_en=1 and the mac_* operand outputs combinationally from req_*.
REQ-010 SHALL compute req_ready = mac_rdy_get && state==RUN && credits>0, where credits = RSP_DEPTH − (in-flight count + FIFO occupancy).
REQ-011 SHALL track each issue in a MAC_LAT-stage shift register of {valid, tag} and sample mac_result into the FIFO exactly MAC_LAT cycles after issue.
REQ-012 SHALL sustain one issue per cycle; repeated identical operands SHALL be issued and produce one response each.
REQ-013 SHALL set err when a stage-MAC_LAT capture occurs with mac_rdy_result=0; the capture SHALL still be performed.
REQ-014 SHALL drive rsp_valid high whenever the FIFO is non-empty, with rsp_data/rsp_tag from the head entry; it SHALL pop on rsp_valid && rsp_ready.
REQ-015 SHALL treat a simultaneous capture and pop, including on a full FIFO, as occupancy unchanged with no data loss.
REQ-016 SHALL wrap FIFO pointers modulo RSP_DEPTH, using an extra wrap bit to distinguish full from empty.
REQ-017 SHALL implement FSM states IDLE, RUN, DRAIN: IDLE→RUN on the first cycle after reset; RUN→DRAIN when flush=1; DRAIN→IDLE when in-flight=0 and the FIFO is empty; IDLE→RUN when flush=0.
REQ-018 SHALL, in DRAIN, hold req_ready=0 while in-flight results continue to be captured and delivered.
REQ-019 SHALL assert busy whenever state≠IDLE, so that busy=0 only in IDLE.
REQ-020 SHALL ensure that in-flight count + occupancy never exceeds RSP_DEPTH; responses are never dropped.

Reset
REQ-021 SHALL, on RST, set: state IDLE; req_ready 0; mac_en 0; mac_* operand outputs 0; rsp_valid 0; rsp_data 0; rsp_tag 0; busy 0; err 0; pointers 0; shift register cleared.
REQ-022 SHALL discard in-flight results when RST is asserted mid-operation; results arriving after reset release SHALL be ignored.

Configuration
REQ-023 SHALL, with MAC_ISSUE_STATS_EN defined, add outputs stat_issued (32), stat_completed (32) and stat_stall (32); stat_stall counts cycles with req_valid && !req_ready.
REQ-024 SHALL make all three counters saturating and cleared by RST.
REQ-025 SHALL, without MAC_ISSUE_STATS_EN, have neither these ports nor these counters; all other behaviour SHALL be identical.

Structure
REQ-026 SHALL place the FSM state typedef, the default MAC_LAT and RSP_DEPTH constants, and the tag width in the shared package mac_vfu_pkg.
REQ-027 SHALL instantiate one sub-module, mac_rsp_fifo (64+4 bits wide, RSP_DEPTH deep).

Verification
REQ-028 SHALL cover: single request m1=3, m2=5, addend=7, tag=1 -> rsp_valid exactly MAC_LAT+1 cycles later, rsp_data=22, tag=1.
REQ-029 SHALL cover: 8 back-to-back requests with rsp_ready=1 -> 8 responses, in order, tags 0..7, with no req_ready bubbles.
REQ-030 SHALL cover: rsp_ready=0 with 6 requests offered -> exactly 4 accepted, req_ready=0 thereafter; with rsp_ready=1, all remaining complete with no loss.
REQ-031 SHALL cover: three identical requests 2×2+0 -> three responses of 4.
REQ-032 SHALL cover: flush asserted with 2 requests in flight -> state DRAIN, req_ready=0, both responses delivered, then busy=0.
REQ-033 SHALL cover: RST mid-flight -> no rsp_valid after release, and err=0.

Source files
------------

// File: rtl/mac_vfu_pkg.sv
// Shared types and default constants for the MAC vector-unit issue path.
package mac_vfu_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam int MAC_LAT_DEF   = 3;
    localparam int RSP_DEPTH_DEF = 4;
    localparam int TAG_W         = 4;

endpackage

// File: rtl/mac_rsp_fifo.sv
// Response FIFO for the MAC issue controller; wrap-bit pointers, head entry read combinationally.
module mac_rsp_fifo #(
    parameter int WIDTH = 68,
    parameter int DEPTH = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    // A push into a full FIFO is only legal when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);

    assign head_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)
                rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    always_ff @(posedge CLK) begin
        if (do_push)
            mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/mac_issue_ctrl.sv
// Credit-based issue controller in front of a fixed-latency MAC unit.
// Optional statistics counters are enabled by defining MAC_ISSUE_STATS_EN.
module mac_issue_ctrl
    import mac_vfu_pkg::*;
#(
    parameter int MAC_LAT   = MAC_LAT_DEF,
    parameter int RSP_DEPTH = RSP_DEPTH_DEF
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [31:0]      req_m1,
    input  logic [31:0]      req_m2,
    input  logic [31:0]      req_addend,
    input  logic [TAG_W-1:0] req_tag,
    output logic [31:0]      mac_multiplicand1,
    output logic [31:0]      mac_multiplicand2,
    output logic [31:0]      mac_addend,
    output logic             mac_en,
    input  logic             mac_rdy_get,
    input  logic [63:0]      mac_result,
    input  logic             mac_rdy_result,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [63:0]      rsp_data,
    output logic [TAG_W-1:0] rsp_tag,
    input  logic             flush,
    output logic             busy,
    output logic             err
`ifdef MAC_ISSUE_STATS_EN
    ,
    output logic [31:0]      stat_issued,
    output logic [31:0]      stat_completed,
    output logic [31:0]      stat_stall
`endif
);

    localparam int OW = $clog2(RSP_DEPTH) + 1;
    localparam logic [OW-1:0] DEPTH_V = OW'(RSP_DEPTH);

    state_t             state;
    state_t             state_nx;
    logic [OW-1:0]      outstanding;
    logic [OW-1:0]      credit_use;
    logic [MAC_LAT-1:0] sr_valid;
    logic [TAG_W-1:0]   sr_tag [MAC_LAT];
    logic               issue;
    logic               capture;
    logic               pop;
    logic               inflight_any;
    logic               fifo_empty;
    logic [63+TAG_W:0]  head;

    assign pop          = rsp_valid && rsp_ready;
    assign capture      = sr_valid[MAC_LAT-1];
    assign inflight_any = |sr_valid;
    // The head entry leaving this cycle frees its slot for a request issued this cycle.
    assign credit_use   = outstanding - OW'(pop);

    assign issue             = req_valid && req_ready;
    assign mac_en            = issue;
    assign mac_multiplicand1 = issue ? req_m1     : 32'd0;
    assign mac_multiplicand2 = issue ? req_m2     : 32'd0;
    assign mac_addend        = issue ? req_addend : 32'd0;

    assign rsp_valid = !fifo_empty;
    assign rsp_data  = head[TAG_W +: 64];
    assign rsp_tag   = head[TAG_W-1:0];

    always_ff @(posedge CLK) begin
        if (RST)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        req_ready = 1'b0;
        busy      = (state != IDLE);
        unique case (state)
            IDLE:    if (!flush) state_nx = RUN;
            RUN: begin
                req_ready = mac_rdy_get && (credit_use < DEPTH_V);
                if (flush) state_nx = DRAIN;
            end
            DRAIN:   if (!inflight_any && fifo_empty) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // outstanding = results in the MAC pipe plus results waiting in the FIFO.
    always_ff @(posedge CLK) begin
        if (RST)
            outstanding <= '0;
        else
            outstanding <= outstanding + OW'(issue) - OW'(pop);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            sr_valid <= '0;
            for (int i = 0; i < MAC_LAT; i++)
                sr_tag[i] <= '0;
        end else begin
            sr_valid[0] <= issue;
            sr_tag[0]   <= req_tag;
            for (int i = 1; i < MAC_LAT; i++) begin
                sr_valid[i] <= sr_valid[i-1];
                sr_tag[i]   <= sr_tag[i-1];
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST)
            err <= 1'b0;
        else if (capture && !mac_rdy_result)
            err <= 1'b1;
    end

    mac_rsp_fifo #(
        .WIDTH (64 + TAG_W),
        .DEPTH (RSP_DEPTH)
    ) u_rsp_fifo (
        .CLK       (CLK),
        .RST       (RST),
        .push      (capture),
        .push_data ({mac_result, sr_tag[MAC_LAT-1]}),
        .pop       (pop),
        .head_data (head),
        .empty     (fifo_empty)
    );

`ifdef MAC_ISSUE_STATS_EN
    localparam logic [31:0] STAT_MAX = '1;

    always_ff @(posedge CLK) begin
        if (RST) begin
            stat_issued    <= '0;
            stat_completed <= '0;
            stat_stall     <= '0;
        end else begin
            if (issue && stat_issued != STAT_MAX)
                stat_issued <= stat_issued + 32'd1;
            if (pop && stat_completed != STAT_MAX)
                stat_completed <= stat_completed + 32'd1;
            if (req_valid && !req_ready && stat_stall != STAT_MAX)
                stat_stall <= stat_stall + 32'd1;
        end
    end
`else
    // Statistics build option disabled: no counters.
`endif

endmodule

// File: tb/tb_mac_issue_ctrl.sv
// Directed self-checking bench for mac_issue_ctrl with a behavioural fixed-latency MAC.
`timescale 1ns/1ps
module tb_mac_issue_ctrl;

    localparam int LAT   = 3;
    localparam int DEPTH = 4;

    logic        CLK = 1'b0;
    logic        RST;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_m1;
    logic [31:0] req_m2;
    logic [31:0] req_addend;
    logic [3:0]  req_tag;
    logic [31:0] mac_multiplicand1;
    logic [31:0] mac_multiplicand2;
    logic [31:0] mac_addend;
    logic        mac_en;
    logic        mac_rdy_get;
    logic [63:0] mac_result;
    logic        mac_rdy_result;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [63:0] rsp_data;
    logic [3:0]  rsp_tag;
    logic        flush;
    logic        busy;
    logic        err;
`ifdef MAC_ISSUE_STATS_EN
    logic [31:0] stat_issued;
    logic [31:0] stat_completed;
    logic [31:0] stat_stall;
`endif

    logic            drop_rdy;
    logic [LAT-1:0]  pv = '0;
    logic [63:0]     pd [LAT];
    int              checks;
    int              errors;
    int              got;
    int              acc;
    logic [63:0]     flush_exp [2];

    always #5 CLK = ~CLK;

    mac_issue_ctrl #(
        .MAC_LAT   (LAT),
        .RSP_DEPTH (DEPTH)
    ) dut (
        .CLK               (CLK),
        .RST               (RST),
        .req_valid         (req_valid),
        .req_ready         (req_ready),
        .req_m1            (req_m1),
        .req_m2            (req_m2),
        .req_addend        (req_addend),
        .req_tag           (req_tag),
        .mac_multiplicand1 (mac_multiplicand1),
        .mac_multiplicand2 (mac_multiplicand2),
        .mac_addend        (mac_addend),
        .mac_en            (mac_en),
        .mac_rdy_get       (mac_rdy_get),
        .mac_result        (mac_result),
        .mac_rdy_result    (mac_rdy_result),
        .rsp_valid         (rsp_valid),
        .rsp_ready         (rsp_ready),
        .rsp_data          (rsp_data),
        .rsp_tag           (rsp_tag),
        .flush             (flush),
        .busy              (busy),
        .err               (err)
`ifdef MAC_ISSUE_STATS_EN
        ,
        .stat_issued       (stat_issued),
        .stat_completed    (stat_completed),
        .stat_stall        (stat_stall)
`endif
    );

    // External MAC: result appears LAT cycles after mac_en, independent of RST.
    always @(posedge CLK) begin
        pv[0] <= mac_en;
        pd[0] <= 64'(mac_multiplicand1) * 64'(mac_multiplicand2) + 64'(mac_addend);
        for (int i = 1; i < LAT; i++) begin
            pv[i] <= pv[i-1];
            pd[i] <= pd[i-1];
        end
    end

    assign mac_result     = pv[LAT-1] ? pd[LAT-1] : 64'd0;
    assign mac_rdy_result = pv[LAT-1] && !drop_rdy;

    task automatic nextCycle();
        @(negedge CLK);
    endtask

    task automatic applyStimulus(input logic v, input logic [31:0] m1, input logic [31:0] m2,
                                 input logic [31:0] add, input logic [3:0] tag);
        req_valid  = v;
        req_m1     = m1;
        req_m2     = m2;
        req_addend = add;
        req_tag    = tag;
    endtask

    task automatic checkOutput(input string name, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", name, observed, expected);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        RST = 1'b1;
        flush = 1'b0;
        rsp_ready = 1'b0;
        mac_rdy_get = 1'b1;
        drop_rdy = 1'b0;
        flush_exp[0] = 64'd2;
        flush_exp[1] = 64'd6;

        // Reset: outputs quiet even with a request presented.
        applyStimulus(1'b1, 32'd9, 32'd9, 32'd9, 4'hF);
        repeat (3) nextCycle();
        #1;
        checkOutput("rst_req_ready", 64'(req_ready), 64'd0);
        checkOutput("rst_mac_en", 64'(mac_en), 64'd0);
        checkOutput("rst_mac_m1", 64'(mac_multiplicand1), 64'd0);
        checkOutput("rst_mac_addend", 64'(mac_addend), 64'd0);
        checkOutput("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        checkOutput("rst_rsp_data", rsp_data, 64'd0);
        checkOutput("rst_rsp_tag", 64'(rsp_tag), 64'd0);
        checkOutput("rst_busy", 64'(busy), 64'd0);
        checkOutput("rst_err", 64'(err), 64'd0);

        RST = 1'b0;
        applyStimulus(1'b0, 32'd0, 32'd0, 32'd0, 4'd0);
        nextCycle();
        #1;
        checkOutput("run_busy", 64'(busy), 64'd1);
        checkOutput("run_req_ready", 64'(req_ready), 64'd1);

        // Single request 3*5+7 tag 1: response exactly LAT+1 cycles after issue.
        applyStimulus(1'b1, 32'd3, 32'd5, 32'd7, 4'd1);
        #1;
        checkOutput("single_mac_en", 64'(mac_en), 64'd1);
        checkOutput("single_mac_m1", 64'(mac_multiplicand1), 64'd3);
        checkOutput("single_mac_m2", 64'(mac_multiplicand2), 64'd5);
        checkOutput("single_mac_addend", 64'(mac_addend), 64'd7);
        nextCycle();
        applyStimulus(1'b0, 32'd0, 32'd0, 32'd0, 4'd0);
        #1;
        checkOutput("single_rsp_valid_0", 64'(rsp_valid), 64'd0);
        for (int k = 1; k <= LAT; k++) begin
            nextCycle();
            #1;
            checkOutput("single_rsp_valid_k", 64'(rsp_valid), 64'(k == LAT));
        end
        checkOutput("single_rsp_data", rsp_data, 64'd22);
        checkOutput("single_rsp_tag", 64'(rsp_tag), 64'd1);
        rsp_ready = 1'b1;
        nextCycle();
        #1;
        checkOutput("single_popped", 64'(rsp_valid), 64'd0);

        // Eight back-to-back requests: (c+1)*2+c = 3c+2, tags 0..7, no ready bubbles.
        got = 0;
        for (int c = 0; c < 24; c++) begin
            if (c < 8)
                applyStimulus(1'b1, 32'(c + 1), 32'd2, 32'(c), 4'(c));
            else
                applyStimulus(1'b0, 32'd0, 32'd0, 32'd0, 4'd0);
            #1;
            if (c < 8)
                checkOutput("b2b_req_ready", 64'(req_ready), 64'd1);
            if (rsp_valid) begin
                checkOutput("b2b_tag", 64'(rsp_tag), 64'(got));
                checkOutput("b2b_data", rsp_data, 64'(3 * got + 2));
                got++;
            end
            nextCycle();
        end
        checkOutput("b2b_count", 64'(got), 64'd8);

        // Three identical 2*2+0 requests each produce their own response.
        got = 0;
        for (int c = 0; c < 12; c++) begin
            if (c < 3)
                applyStimulus(1'b1, 32'd2, 32'd2, 32'd0, 4'(8 + c));
            else
                applyStimulus(1'b0, 32'd0, 32'd0, 32'd0, 4'd0);
            #1;
            if (rsp_valid) begin
                checkOutput("ident_tag", 64'(rsp_tag), 64'(8 + got));
                checkOutput("ident_data", rsp_data, 64'd4);
                got++;
            end
            nextCycle();
        end
        checkOutput("ident_count", 64'(got), 64'd3);

        // Backpressure: six offered, only DEPTH accepted while rsp_ready=0.
        rsp_ready = 1'b0;
        acc = 0;
        for (int c = 0; c < 10; c++) begin
            if (acc < 6)
                applyStimulus(1'b1, 32'(acc), 32'd10, 32'd1, 4'(acc));
            else
                applyStimulus(1'b0, 32'd0, 32'd0, 32'd0, 4'd0);
            #1;
            if (req_valid && req_ready)
                acc++;
            nextCycle();
        end
        #1;
        checkOutput("bp_accepted", 64'(acc), 64'd4);
        checkOutput("bp_req_ready", 64'(req_ready), 64'd0);
        checkOutput("bp_rsp_valid", 64'(rsp_valid), 64'd1);
        checkOutput("bp_head_tag", 64'(rsp_tag), 64'd0);
        rsp_ready = 1'b1;
        got = 0;
        for (int c = 0; c < 16; c++) begin
            if (acc < 6)
                applyStimulus(1'b1, 32'(acc), 32'd10, 32'd1, 4'(acc));
            else
                applyStimulus(1'b0, 32'd0, 32'd0, 32'd0, 4'd0);
            #1;
            if (rsp_valid) begin
                checkOutput("bp_tag", 64'(rsp_tag), 64'(got));
                checkOutput("bp_data", rsp_data, 64'(10 * got + 1));
                got++;
            end
            if (req_valid && req_ready)
                acc++;
            nextCycle();
        end
        checkOutput("bp_total_accepted", 64'(acc), 64'd6);
        checkOutput("bp_total_rsp", 64'(got), 64'd6);
        checkOutput("bp_err", 64'(err), 64'd0);

        // Flush with two in flight: drain delivers both, then idle.
        applyStimulus(1'b1, 32'd1, 32'd1, 32'd1, 4'd3);
        nextCycle();
        applyStimulus(1'b1, 32'd2, 32'd3, 32'd0, 4'd4);
        nextCycle();
        applyStimulus(1'b0, 32'd0, 32'd0, 32'd0, 4'd0);
        flush = 1'b1;
        nextCycle();
        applyStimulus(1'b1, 32'd7, 32'd7, 32'd7, 4'hF);
        #1;
        checkOutput("flush_busy_drain", 64'(busy), 64'd1);
        checkOutput("flush_req_ready", 64'(req_ready), 64'd0);
        checkOutput("flush_mac_en", 64'(mac_en), 64'd0);
        got = 0;
        for (int c = 0; c < 15 && busy; c++) begin
            if (rsp_valid) begin
                checkOutput("flush_tag", 64'(rsp_tag), 64'(3 + got));
                checkOutput("flush_data", rsp_data, flush_exp[got % 2]);
                got++;
            end
            checkOutput("flush_hold_ready", 64'(req_ready), 64'd0);
            nextCycle();
            #1;
        end
        checkOutput("flush_busy_end", 64'(busy), 64'd0);
        checkOutput("flush_rsp_count", 64'(got), 64'd2);
        flush = 1'b0;
        applyStimulus(1'b0, 32'd0, 32'd0, 32'd0, 4'd0);
        nextCycle();
        #1;
        checkOutput("flush_rerun_busy", 64'(busy), 64'd1);
        checkOutput("flush_rerun_ready", 64'(req_ready), 64'd1);

        // Reset mid-flight: in-flight results are discarded.
        applyStimulus(1'b1, 32'd5, 32'd5, 32'd5, 4'd1);
        nextCycle();
        applyStimulus(1'b1, 32'd6, 32'd6, 32'd6, 4'd2);
        nextCycle();
        applyStimulus(1'b0, 32'd0, 32'd0, 32'd0, 4'd0);
        rsp_ready = 1'b0;
        RST = 1'b1;
        nextCycle();
        #1;
        checkOutput("midrst_busy", 64'(busy), 64'd0);
        checkOutput("midrst_rsp_valid", 64'(rsp_valid), 64'd0);
        checkOutput("midrst_req_ready", 64'(req_ready), 64'd0);
        RST = 1'b0;
        for (int c = 0; c < 8; c++) begin
            nextCycle();
            #1;
            checkOutput("midrst_no_rsp", 64'(rsp_valid), 64'd0);
            checkOutput("midrst_err", 64'(err), 64'd0);
        end
        checkOutput("midrst_rerun", 64'(busy), 64'd1);

        // Capture without mac_rdy_result: err sets, result still delivered.
        drop_rdy = 1'b1;
        applyStimulus(1'b1, 32'd4, 32'd4, 32'd4, 4'd6);
        nextCycle();
        applyStimulus(1'b0, 32'd0, 32'd0, 32'd0, 4'd0);
        nextCycle();
        nextCycle();
        #1;
        checkOutput("err_before", 64'(err), 64'd0);
        nextCycle();
        #1;
        checkOutput("err_set", 64'(err), 64'd1);
        checkOutput("err_rsp_valid", 64'(rsp_valid), 64'd1);
        checkOutput("err_rsp_data", rsp_data, 64'd20);
        checkOutput("err_rsp_tag", 64'(rsp_tag), 64'd6);
        drop_rdy = 1'b0;
        rsp_ready = 1'b1;
        nextCycle();
        #1;
        checkOutput("err_popped", 64'(rsp_valid), 64'd0);
        checkOutput("err_sticky", 64'(err), 64'd1);
`ifdef MAC_ISSUE_STATS_EN
        checkOutput("stat_issued", 64'(stat_issued), 64'd1);
        checkOutput("stat_completed", 64'(stat_completed), 64'd1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
